mips_multicycle_controller: RTL and testbench
=============================================

Name: mips_multicycle_controller

Overview:
Moore-style main control FSM that sequences the shared multicycle MIPS datapath (single memory, single ALU, IR/MDR/A/B/ALUOut registers) through fetch, decode, execute, memory and write-back steps. It decodes opcode/funct from the instruction register and drives every mux select, register enable and memory strobe each cycle. It sits beside the multicycle datapath in the multicycle CPU top and replaces the single-cycle combinational controller.

Parameters:
ILLEGAL_TRAP, 0, 0: unknown opcode/funct returns to FETCH; 1: enters HALT until reset.

Ports:
clk  in  1  rising-edge clock
rst  in  1  asynchronous active-low reset
opcode  in  6  IR[31:26]
funct  in  6  IR[5:0]
zero  in  1  ALU zero flag
pc_ld  out  1  PC load = pc_write | (branch & zero)
i_or_d  out  1  memory address: 0 PC, 1 ALUOut
mem_read  out  1  memory read strobe
mem_write  out  1  memory write strobe
ir_write  out  1  IR load enable
reg_dst  out  2  00 rt, 01 rd, 10 $31
mem_to_reg  out  2  00 ALUOut, 01 MDR, 10 PC
reg_write  out  1  register-file write enable
alu_src_a  out  1  0 PC, 1 A
alu_src_b  out  2  00 B, 01 const 4, 10 sext(imm), 11 sext(imm)<<2
alu_ctrl  out  3  010 add, 110 sub, 000 and, 001 or, 111 slt
pc_src  out  2  00 ALU result, 01 ALUOut, 10 {PC[31:28],IR[25:0],2'b00}, 11 A
state  out  4  current state code (debug/verification)
illegal  out  1  1-cycle pulse in DECODE on unsupported encoding

Behaviour:
- rst low (async): state=FETCH immediately. All outputs are decoded from state (plus zero for pc_ld). Outputs are never forced to 0 during reset: they take their FETCH values, as listed below. FETCH is entered in the first cycle after reset release.
- Default for every output not listed per state: 0 (alu_ctrl=010).
- FETCH(0): mem_read, ir_write, alu_src_a=0, alu_src_b=01, add, pc_src=00, pc_write -> DECODE.
- DECODE(1): alu_src_a=0, alu_src_b=11, add (branch target into ALUOut). Next state by opcode:
  - 100011 lw or 101011 sw -> MEM_ADR.
  - 000000 with funct add/sub/and/or/slt (100000/100010/100100/100101/101010) -> RT_EXE.
  - 000000 with funct 001000 -> JR.
  - 000100 -> BEQ.
  - 001000 addi or 001010 slti -> IMM_EXE.
  - 000010 -> J.
  - 000011 -> JAL.
  - Any other encoding -> illegal=1, then FETCH (or HALT when ILLEGAL_TRAP=1).
- MEM_ADR(2): alu_src_a=1, alu_src_b=10, add -> MEM_RD (lw) / MEM_WR (sw).
- MEM_RD(3): mem_read, i_or_d=1 -> MEM_WB.
- MEM_WB(4): reg_write, reg_dst=00, mem_to_reg=01 -> FETCH.
- MEM_WR(5): mem_write, i_or_d=1 -> FETCH.
- RT_EXE(6): alu_src_a=1, alu_src_b=00, alu_ctrl from funct -> RT_WB.
- RT_WB(7): reg_write, reg_dst=01, mem_to_reg=00 -> FETCH.
- BEQ(8): alu_src_a=1, alu_src_b=00, sub, branch=1, pc_src=01, so pc_ld=zero -> FETCH.
- IMM_EXE(9): alu_src_a=1, alu_src_b=10, add (addi) / slt (slti) -> IMM_WB.
- IMM_WB(10): reg_write, reg_dst=00, mem_to_reg=00 -> FETCH.
- J(11): pc_src=10, pc_write -> FETCH.
- JAL(12): pc_src=10, pc_write, reg_write, reg_dst=10, mem_to_reg=10 -> FETCH. The register file captures PC+4 (held in PC since FETCH) on the same edge PC updates.
- JR(13): pc_src=11, pc_write -> FETCH.
- HALT(15): all strobes 0, self-loop; exit only via reset.
- State 14 is unused; it recovers to FETCH.
- Cycles per instruction: lw 5; sw, R-type, addi and slti 4; beq, j, jal and jr 3.
- The controller latches the decode-state opcode for use in MEM_ADR and IMM_EXE. IR is not rewritten until the next FETCH, so reading opcode live is also valid.
- Reset asserted in any state aborts the instruction: no mem_write or reg_write is issued after the asynchronous assertion.

Test Plan:
- Reset then lw (opcode 100011): state sequence 0,1,2,3,4,0; mem_read high in states 0 and 3; i_or_d=1 only in 3; reg_write=1 with mem_to_reg=01 only in 4.
- R-type sub (funct 100010) then sw: alu_ctrl=110 in RT_EXE, reg_dst=01 in RT_WB. The sw then completes in 4 cycles with mem_write=1 only in MEM_WR.
- beq with zero=1: pc_ld=1, pc_src=01 in state 8. Repeat with zero=0: pc_ld=0 in state 8, and the next FETCH follows.
- jal: state 12 reached on cycle 3 with pc_ld=1, reg_write=1, reg_dst=10, mem_to_reg=10, pc_src=10. jr (000000/001000) reaches state 13 with pc_src=11.
- slti (001010): state sequence 0,1,9,10 with alu_ctrl=111 in 9. Opcode 111111: illegal pulses in DECODE, then FETCH (ILLEGAL_TRAP=0) or HALT with no strobes for 10 cycles (ILLEGAL_TRAP=1).
- Drop rst to 0 mid-MEM_WR, asynchronously between edges: mem_write falls without waiting for a clock, state=0. After release, fetch resumes at the next edge.

Source files
------------

// File: rtl/mips_multicycle_controller_if.sv
// Control bundle between the multicycle MIPS main controller and its datapath.
// The controller side uses the master modport; the datapath side uses slave.
interface mips_multicycle_controller_if;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       zero;
    logic       pc_ld;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic [1:0] reg_dst;
    logic [1:0] mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_ctrl;
    logic [1:0] pc_src;
    logic [3:0] state;
    logic       illegal;

    modport master (
        input  opcode, funct, zero,
        output pc_ld, i_or_d, mem_read, mem_write, ir_write, reg_dst, mem_to_reg,
               reg_write, alu_src_a, alu_src_b, alu_ctrl, pc_src, state, illegal
    );

    modport slave (
        output opcode, funct, zero,
        input  pc_ld, i_or_d, mem_read, mem_write, ir_write, reg_dst, mem_to_reg,
               reg_write, alu_src_a, alu_src_b, alu_ctrl, pc_src, state, illegal
    );
endinterface

// File: rtl/mips_multicycle_controller.sv
// Moore main control FSM for the shared-memory multicycle MIPS datapath.
// Control outputs are registered alongside the state so they track it exactly.
module mips_multicycle_controller #(
    parameter bit ILLEGAL_TRAP = 1'b0
) (
    input logic clk,
    input logic rst,
    mips_multicycle_controller_if.master bus
);

    typedef enum logic [3:0] {
        StFetch  = 4'd0,  StDecode = 4'd1,  StMemAdr = 4'd2,  StMemRd  = 4'd3,
        StMemWb  = 4'd4,  StMemWr  = 4'd5,  StRtExe  = 4'd6,  StRtWb   = 4'd7,
        StBeq    = 4'd8,  StImmExe = 4'd9,  StImmWb  = 4'd10, StJ      = 4'd11,
        StJal    = 4'd12, StJr     = 4'd13, StSpare  = 4'd14, StHalt   = 4'd15
    } state_e;

    typedef struct packed {
        logic       pc_write;
        logic       branch;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic [1:0] reg_dst;
        logic [1:0] mem_to_reg;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] alu_ctrl;
        logic [1:0] pc_src;
    } ctl_t;

    localparam logic [5:0] OpRtype = 6'b000000;
    localparam logic [5:0] OpJ     = 6'b000010;
    localparam logic [5:0] OpJal   = 6'b000011;
    localparam logic [5:0] OpBeq   = 6'b000100;
    localparam logic [5:0] OpAddi  = 6'b001000;
    localparam logic [5:0] OpSlti  = 6'b001010;
    localparam logic [5:0] OpLw    = 6'b100011;
    localparam logic [5:0] OpSw    = 6'b101011;
    localparam logic [5:0] FnJr    = 6'b001000;

    function automatic logic [2:0] rt_alu(input logic [5:0] fn);
        case (fn)
            6'b100010: rt_alu = 3'b110;
            6'b100100: rt_alu = 3'b000;
            6'b100101: rt_alu = 3'b001;
            6'b101010: rt_alu = 3'b111;
            default:   rt_alu = 3'b010;
        endcase
    endfunction

    function automatic logic rt_ok(input logic [5:0] fn);
        rt_ok = (fn == 6'b100000) || (fn == 6'b100010) || (fn == 6'b100100) ||
                (fn == 6'b100101) || (fn == 6'b101010);
    endfunction

    // op/fn are the live IR fields; only meaningful when s is entered from DECODE.
    function automatic ctl_t ctl_for(input state_e s, input logic [5:0] op,
                                     input logic [5:0] fn);
        ctl_t c;
        c = '0;
        c.alu_ctrl = 3'b010;
        case (s)
            StFetch: begin
                c.mem_read  = 1'b1;
                c.ir_write  = 1'b1;
                c.alu_src_b = 2'b01;
                c.pc_write  = 1'b1;
            end
            StDecode: c.alu_src_b = 2'b11;
            StMemAdr: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = 2'b10;
            end
            StMemRd: begin
                c.mem_read = 1'b1;
                c.i_or_d   = 1'b1;
            end
            StMemWb: begin
                c.reg_write  = 1'b1;
                c.mem_to_reg = 2'b01;
            end
            StMemWr: begin
                c.mem_write = 1'b1;
                c.i_or_d    = 1'b1;
            end
            StRtExe: begin
                c.alu_src_a = 1'b1;
                c.alu_ctrl  = rt_alu(fn);
            end
            StRtWb: begin
                c.reg_write = 1'b1;
                c.reg_dst   = 2'b01;
            end
            StBeq: begin
                c.alu_src_a = 1'b1;
                c.alu_ctrl  = 3'b110;
                c.branch    = 1'b1;
                c.pc_src    = 2'b01;
            end
            StImmExe: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = 2'b10;
                c.alu_ctrl  = (op == OpSlti) ? 3'b111 : 3'b010;
            end
            StImmWb: c.reg_write = 1'b1;
            StJ: begin
                c.pc_src   = 2'b10;
                c.pc_write = 1'b1;
            end
            StJal: begin
                c.pc_src     = 2'b10;
                c.pc_write   = 1'b1;
                c.reg_write  = 1'b1;
                c.reg_dst    = 2'b10;
                c.mem_to_reg = 2'b10;
            end
            StJr: begin
                c.pc_src   = 2'b11;
                c.pc_write = 1'b1;
            end
            default: ;
        endcase
        return c;
    endfunction

    state_e     state_q, state_d;
    ctl_t       ctl_q;
    logic [5:0] op_q;
    logic       legal;

    always_comb begin
        legal   = 1'b1;
        state_d = StFetch;
        case (state_q)
            StFetch:  state_d = StDecode;
            StDecode: begin
                case (bus.opcode)
                    OpLw, OpSw:     state_d = StMemAdr;
                    OpBeq:          state_d = StBeq;
                    OpAddi, OpSlti: state_d = StImmExe;
                    OpJ:            state_d = StJ;
                    OpJal:          state_d = StJal;
                    OpRtype: begin
                        if (rt_ok(bus.funct))      state_d = StRtExe;
                        else if (bus.funct == FnJr) state_d = StJr;
                        else                        legal = 1'b0;
                    end
                    default:        legal = 1'b0;
                endcase
                if (!legal) state_d = ILLEGAL_TRAP ? StHalt : StFetch;
            end
            StMemAdr: state_d = (op_q == OpLw) ? StMemRd : StMemWr;
            StMemRd:  state_d = StMemWb;
            StRtExe:  state_d = StRtWb;
            StImmExe: state_d = StImmWb;
            StHalt:   state_d = StHalt;
            default:  state_d = StFetch;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StFetch;
            op_q    <= 6'd0;
            ctl_q   <= ctl_for(StFetch, 6'd0, 6'd0);
        end else begin
            state_q <= state_d;
            if (state_q == StDecode) op_q <= bus.opcode;
            ctl_q   <= ctl_for(state_d, bus.opcode, bus.funct);
        end
    end

    assign bus.pc_ld      = ctl_q.pc_write | (ctl_q.branch & bus.zero);
    assign bus.i_or_d     = ctl_q.i_or_d;
    assign bus.mem_read   = ctl_q.mem_read;
    assign bus.mem_write  = ctl_q.mem_write;
    assign bus.ir_write   = ctl_q.ir_write;
    assign bus.reg_dst    = ctl_q.reg_dst;
    assign bus.mem_to_reg = ctl_q.mem_to_reg;
    assign bus.reg_write  = ctl_q.reg_write;
    assign bus.alu_src_a  = ctl_q.alu_src_a;
    assign bus.alu_src_b  = ctl_q.alu_src_b;
    assign bus.alu_ctrl   = ctl_q.alu_ctrl;
    assign bus.pc_src     = ctl_q.pc_src;
    assign bus.state      = state_q;
    // IR holds the new instruction only from DECODE on, so this flag stays combinational.
    assign bus.illegal    = (state_q == StDecode) && !legal;

endmodule

// File: tb/tb_mips_multicycle_controller.sv
// Bench for the multicycle MIPS controller: instruction table with a queue of
// expected per-cycle outputs, plus reset-abort and illegal-trap sequences.
module tb_mips_multicycle_controller;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rst1 = 1'b1;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    mips_multicycle_controller_if if0 ();
    mips_multicycle_controller_if if1 ();

    assign if1.opcode = if0.opcode;
    assign if1.funct  = if0.funct;
    assign if1.zero   = if0.zero;

    mips_multicycle_controller #(.ILLEGAL_TRAP(1'b0)) dut0 (
        .clk (clk),
        .rst (rst),
        .bus (if0)
    );

    mips_multicycle_controller #(.ILLEGAL_TRAP(1'b1)) dut1 (
        .clk (clk),
        .rst (rst1),
        .bus (if1)
    );

    typedef struct packed {
        logic [3:0] st;
        logic       pc_ld;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic [1:0] reg_dst;
        logic [1:0] mem_to_reg;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] alu_ctrl;
        logic [1:0] pc_src;
        logic       illegal;
    } exp_t;

    typedef struct packed {
        logic [5:0]      op;
        logic [5:0]      fn;
        logic            z;
        logic [2:0]      len;
        logic [4:0][3:0] seq;
        logic            ill;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[17];

    function automatic vec_t mk(input logic [5:0] op, input logic [5:0] fn, input logic z,
                                input int len, input int s2, input int s3, input int s4,
                                input logic ill);
        vec_t v;
        v.op  = op;
        v.fn  = fn;
        v.z   = z;
        v.len = 3'(len);
        v.seq = {4'(s4), 4'(s3), 4'(s2), 4'd1, 4'd0};
        v.ill = ill;
        return v;
    endfunction

    // Expected outputs per state, written from the state table.
    function automatic exp_t exp_for(input int st, input logic [5:0] op, input logic [5:0] fn,
                                     input logic z, input logic ill);
        exp_t e;
        e = '0;
        e.st = 4'(st);
        e.alu_ctrl = 3'b010;
        case (st)
            0:  begin e.mem_read = 1; e.ir_write = 1; e.alu_src_b = 2'b01; e.pc_ld = 1; end
            1:  begin e.alu_src_b = 2'b11; e.illegal = ill; end
            2:  begin e.alu_src_a = 1; e.alu_src_b = 2'b10; end
            3:  begin e.mem_read = 1; e.i_or_d = 1; end
            4:  begin e.reg_write = 1; e.mem_to_reg = 2'b01; end
            5:  begin e.mem_write = 1; e.i_or_d = 1; end
            6:  begin
                e.alu_src_a = 1;
                if (fn == 6'b100010) e.alu_ctrl = 3'b110;
                else if (fn == 6'b100100) e.alu_ctrl = 3'b000;
                else if (fn == 6'b100101) e.alu_ctrl = 3'b001;
                else if (fn == 6'b101010) e.alu_ctrl = 3'b111;
            end
            7:  begin e.reg_write = 1; e.reg_dst = 2'b01; end
            8:  begin e.alu_src_a = 1; e.alu_ctrl = 3'b110; e.pc_src = 2'b01; e.pc_ld = z; end
            9:  begin
                e.alu_src_a = 1; e.alu_src_b = 2'b10;
                e.alu_ctrl = (op == 6'b001010) ? 3'b111 : 3'b010;
            end
            10: e.reg_write = 1;
            11: begin e.pc_src = 2'b10; e.pc_ld = 1; end
            12: begin
                e.pc_src = 2'b10; e.pc_ld = 1; e.reg_write = 1;
                e.reg_dst = 2'b10; e.mem_to_reg = 2'b10;
            end
            13: begin e.pc_src = 2'b11; e.pc_ld = 1; end
            default: ;
        endcase
        return e;
    endfunction

    task automatic check(input string name, input int act, input int want);
        total++;
        if (act != want) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, want);
        end
    endtask

    task automatic compare(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            check({tag, " queue_empty"}, 1, 0);
            return;
        end
        e = sb.pop_front();
        check({tag, " state"},      int'(if0.state),      int'(e.st));
        check({tag, " pc_ld"},      int'(if0.pc_ld),      int'(e.pc_ld));
        check({tag, " i_or_d"},     int'(if0.i_or_d),     int'(e.i_or_d));
        check({tag, " mem_read"},   int'(if0.mem_read),   int'(e.mem_read));
        check({tag, " mem_write"},  int'(if0.mem_write),  int'(e.mem_write));
        check({tag, " ir_write"},   int'(if0.ir_write),   int'(e.ir_write));
        check({tag, " reg_dst"},    int'(if0.reg_dst),    int'(e.reg_dst));
        check({tag, " mem_to_reg"}, int'(if0.mem_to_reg), int'(e.mem_to_reg));
        check({tag, " reg_write"},  int'(if0.reg_write),  int'(e.reg_write));
        check({tag, " alu_src_a"},  int'(if0.alu_src_a),  int'(e.alu_src_a));
        check({tag, " alu_src_b"},  int'(if0.alu_src_b),  int'(e.alu_src_b));
        check({tag, " alu_ctrl"},   int'(if0.alu_ctrl),   int'(e.alu_ctrl));
        check({tag, " pc_src"},     int'(if0.pc_src),     int'(e.pc_src));
        check({tag, " illegal"},    int'(if0.illegal),    int'(e.illegal));
    endtask

    task automatic push_seq(input vec_t v);
        for (int c = 0; c < int'(v.len); c++)
            sb.push_back(exp_for(int'(v.seq[c]), v.op, v.fn, v.z, v.ill));
    endtask

    initial begin
        vecs[0]  = mk(6'b100011, 6'b000000, 0, 5, 2, 3, 4, 0);   // lw
        vecs[1]  = mk(6'b000000, 6'b100010, 0, 4, 6, 7, 0, 0);   // sub
        vecs[2]  = mk(6'b101011, 6'b000000, 0, 4, 2, 5, 0, 0);   // sw
        vecs[3]  = mk(6'b000100, 6'b000000, 1, 3, 8, 0, 0, 0);   // beq taken
        vecs[4]  = mk(6'b000100, 6'b000000, 0, 3, 8, 0, 0, 0);   // beq not taken
        vecs[5]  = mk(6'b000011, 6'b000000, 0, 3, 12, 0, 0, 0);  // jal
        vecs[6]  = mk(6'b000000, 6'b001000, 0, 3, 13, 0, 0, 0);  // jr
        vecs[7]  = mk(6'b001010, 6'b000000, 0, 4, 9, 10, 0, 0);  // slti
        vecs[8]  = mk(6'b001000, 6'b000000, 0, 4, 9, 10, 0, 0);  // addi
        vecs[9]  = mk(6'b000000, 6'b100000, 0, 4, 6, 7, 0, 0);   // add
        vecs[10] = mk(6'b000000, 6'b100100, 0, 4, 6, 7, 0, 0);   // and
        vecs[11] = mk(6'b000000, 6'b100101, 0, 4, 6, 7, 0, 0);   // or
        vecs[12] = mk(6'b000000, 6'b101010, 1, 4, 6, 7, 0, 0);   // slt, zero ignored
        vecs[13] = mk(6'b000010, 6'b000000, 0, 3, 11, 0, 0, 0);  // j
        vecs[14] = mk(6'b111111, 6'b000000, 0, 2, 0, 0, 0, 1);   // illegal opcode
        vecs[15] = mk(6'b000000, 6'b000001, 0, 2, 0, 0, 0, 1);   // illegal funct
        vecs[16] = mk(6'b100011, 6'b000000, 0, 5, 2, 3, 4, 0);   // lw after illegal

        if0.opcode = 6'b100011;
        if0.funct  = 6'b000000;
        if0.zero   = 1'b0;

        // Reset: outputs hold their FETCH values while rst is low.
        #1 rst = 1'b0;
        rst1 = 1'b0;
        #1;
        sb.push_back(exp_for(0, 6'd0, 6'd0, 1'b0, 1'b0));
        compare("reset");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 17; i++) begin
            if0.opcode = vecs[i].op;
            if0.funct  = vecs[i].fn;
            if0.zero   = vecs[i].z;
            push_seq(vecs[i]);
            for (int c = 0; c < int'(vecs[i].len); c++) begin
                #1;
                compare($sformatf("v%0d c%0d", i, c));
                @(negedge clk);
            end
        end
        #1;
        check("final_fetch state", int'(if0.state), 0);

        // Async reset in the middle of MEM_WR aborts the store without a clock edge.
        if0.opcode = 6'b101011;
        if0.funct  = 6'b000000;
        if0.zero   = 1'b0;
        push_seq(mk(6'b101011, 6'b000000, 0, 4, 2, 5, 0, 0));
        for (int c = 0; c < 4; c++) begin
            #1;
            compare($sformatf("swabort c%0d", c));
            if (c < 3) @(negedge clk);
        end
        #1 rst = 1'b0;
        #1;
        sb.push_back(exp_for(0, 6'd0, 6'd0, 1'b0, 1'b0));
        compare("abort_async");
        @(negedge clk);
        rst = 1'b1;
        push_seq(mk(6'b101011, 6'b000000, 0, 5, 2, 5, 0, 0));
        for (int c = 0; c < 5; c++) begin
            #1;
            compare($sformatf("resume c%0d", c));
            @(negedge clk);
        end

        // Trap instance: illegal opcode parks the FSM in HALT with all strobes low.
        if0.opcode = 6'b111111;
        rst1 = 1'b1;
        #1;
        check("trap fetch state", int'(if1.state), 0);
        @(negedge clk);
        #1;
        check("trap decode state", int'(if1.state), 1);
        check("trap illegal", int'(if1.illegal), 1);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            #1;
            check($sformatf("halt%0d state", c), int'(if1.state), 15);
            check($sformatf("halt%0d strobes", c),
                  int'({if1.pc_ld, if1.mem_read, if1.mem_write, if1.ir_write,
                        if1.reg_write, if1.illegal}), 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
